pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 114 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch PC sequencer with stall, redirect and exception control
module pc_sequencer #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        npc_valid,
    input  logic [31:0] npc_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        if_valid,
    output logic        flush_d,
    output logic        addr_err,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        EXC   = 2'b10
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_pend_valid;
    logic        w_pend_valid_nxt;
    logic [31:0] r_pend_target;
    logic [31:0] w_pend_target_nxt;
    logic        r_addr_err;
    logic        w_misalign;
    logic [15:0] r_stall_cnt;
    logic [31:0] w_pc4;

    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_target_nxt = r_pend_target;
        w_misalign        = 1'b0;
        case (r_state)
            RUN, STALL: begin
                if (exc_req) begin
                    w_pc_nxt         = EXC_VECTOR;
                    w_pend_valid_nxt = 1'b0;
                    w_state_nxt      = EXC;
                end else if (eret_req) begin
                    w_pc_nxt         = {epc[31:2], 2'b00};
                    w_misalign       = (epc[1:0] != 2'b00);
                    w_pend_valid_nxt = 1'b0;
                    w_state_nxt      = EXC;
                end else if (stall) begin
                    // A redirect arriving during a stall is parked until fetch resumes
                    if (npc_valid) begin
                        w_pend_valid_nxt  = 1'b1;
                        w_pend_target_nxt = npc_target;
                    end
                    w_state_nxt = STALL;
                end else if ((r_state == STALL) && r_pend_valid) begin
                    w_pc_nxt         = {r_pend_target[31:2], 2'b00};
                    w_misalign       = (r_pend_target[1:0] != 2'b00);
                    w_pend_valid_nxt = 1'b0;
                    w_state_nxt      = RUN;
                end else if (npc_valid) begin
                    w_pc_nxt    = {npc_target[31:2], 2'b00};
                    w_misalign  = (npc_target[1:0] != 2'b00);
                    w_state_nxt = RUN;
                end else begin
                    w_pc_nxt    = w_pc4;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'd0;
            r_addr_err    <= 1'b0;
            r_stall_cnt   <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_addr_err    <= w_misalign;
            if ((r_state == STALL) && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign pc        = r_pc;
    assign pc4       = w_pc4;
    assign if_valid  = (r_state == RUN);
    assign flush_d   = (r_state == EXC);
    assign addr_err  = r_addr_err;
    assign stall_cnt = r_stall_cnt;

endmodule
